// File: rtl/spi_ram_pkg.sv
// Shared opcode encoding and pointer arithmetic for the SPI-side RAM controller.
package spi_ram_pkg;

    typedef logic [1:0] opcode_t;

    localparam opcode_t OP_WADDR = 2'b00;
    localparam opcode_t OP_WDATA = 2'b01;
    localparam opcode_t OP_RADDR = 2'b10;
    localparam opcode_t OP_RDATA = 2'b11;

    // Advance a pointer by one, wrapping to zero after the last valid word.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM, DEPTH x DATA_W, with a registered read port.
module spi_ram_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array and rdata carry no reset; resetting a RAM would stop it
    // mapping onto block memory, and the controller masks rdata after reset.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/spi_ram_burst.sv
// SPI-side RAM controller: decodes opcode+payload command words into pointer
// loads, writes and reads, with optional auto-increment burst addressing.
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int ADDR_W   = 8,
    parameter  int DEPTH    = 256,
    parameter  int AUTO_INC = 1,
    localparam int PLD_W    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PLD_W+1:0]  din,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              addr_err,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam bit              INC     = (AUTO_INC != 0);

    opcode_t           op;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] wr_data;
    logic              ld_ok;

    assign op      = din[PLD_W+1:PLD_W];
    assign ld_addr = din[ADDR_W-1:0];
    assign wr_data = din[DATA_W-1:0];
    assign ld_ok   = {1'b0, ld_addr} < DEPTH_X;

    logic wr_en, rd_en, wa_ld, ra_ld, ld_bad;

    // NOTE: every output of this block is defaulted first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        wa_ld  = 1'b0;
        ra_ld  = 1'b0;
        ld_bad = 1'b0;
        if (rx_valid) begin
            unique case (op)
                OP_WADDR: begin
                    wa_ld  = ld_ok;
                    ld_bad = !ld_ok;
                end
                OP_WDATA: wr_en = 1'b1;
                OP_RADDR: begin
                    ra_ld  = ld_ok;
                    ld_bad = !ld_ok;
                end
                OP_RDATA: rd_en = 1'b1;
            endcase
        end
    end

    logic [ADDR_W-1:0] wr_next, rd_next;
    assign wr_next = ADDR_W'(wrap_inc(32'(wr_ptr), DEPTH));
    assign rd_next = ADDR_W'(wrap_inc(32'(rd_ptr), DEPTH));

    // Set by the first read after reset; until then dout shows zero instead of
    // the unreset RAM read register.
    logic rd_seen;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, e.g. a write uses wr_ptr before it advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_valid <= 1'b0;
            addr_err <= 1'b0;
            rd_seen  <= 1'b0;
        end else begin
            tx_valid <= rd_en;
            addr_err <= ld_bad;
            if (rd_en) rd_seen <= 1'b1;

            if (wa_ld)             wr_ptr <= ld_addr;
            else if (wr_en && INC) wr_ptr <= wr_next;

            if (ra_ld)             rd_ptr <= ld_addr;
            else if (rd_en && INC) rd_ptr <= rd_next;
        end
    end

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    assign ram_addr = wr_en ? wr_ptr : rd_ptr;

    spi_ram_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .re    (rd_en),
        .addr  (ram_addr),
        .wdata (wr_data),
        .rdata (ram_rdata)
    );

    assign dout = rd_seen ? ram_rdata : '0;

endmodule
